// File: rtl/vector_reorder_pipe.sv
// vector_reorder_pipe
//
// Two-stage pipelined bit/lane reordering unit with valid/ready handshakes
// on both sides. Each accepted word carries its own mode and rotate amount.
// The permuted result reaches the output two cycles after the input
// handshake. Under full flow the unit sustains one word per clock.
//
// Optional feature macro: VECTOR_REORDER_ROTATE_EN
//   defined     -> mode 5 (ROTL) is legal and a log2-stage barrel rotator is built
//   not defined -> no rotator exists, mode 5 is reported as illegal, in_rot ignored
//
// Parameters:
//   LANES   number of lanes (>= 2, even)
//   LANE_W  bits per lane (>= 1)
//
// Ports:
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   in_valid   producer word valid
//   in_ready   unit accepts the producer word this cycle
//   in_data    input word, bit DATA_W-1 is the MSB
//   in_mode    permutation select, bound to the word at its handshake
//   in_rot     rotate-left amount for mode 5, bound to the word at its handshake
//   out_valid  output word valid
//   out_ready  consumer accepts the output word
//   out_data   permuted word (zero when out_err is set)
//   out_err    1 = the word used an illegal mode
//   xfer_cnt   completed output handshakes, wraps 0xFFFF -> 0

module vector_reorder_pipe #(
  parameter  int LANES  = 4,
  parameter  int LANE_W = 4,
  localparam int DATA_W = LANES * LANE_W,
  localparam int ROT_W  = $clog2(DATA_W)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [2:0]        in_mode,
  input  logic [ROT_W-1:0]  in_rot,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_err,
  output logic [15:0]       xfer_cnt
);

  // Permutation codes; codes 6 and 7 fall into the illegal default.
  typedef enum logic [2:0] {
    MODE_PASS     = 3'd0,
    MODE_BITREV   = 3'd1,
    MODE_LANEREV  = 3'd2,
    MODE_INLANE   = 3'd3,
    MODE_SWAPHALF = 3'd4,
    MODE_ROTL     = 3'd5
  } mode_e;

  localparam int HALF_W = DATA_W / 2;

  // Stage 1: captured input word and its per-transaction controls.
  logic              r_s1Valid;
  logic [DATA_W-1:0] r_s1Data;
  mode_e             r_s1Mode;

  // Stage 2: permuted result and error flag, driven straight to the outputs.
  logic              r_s2Valid;
  logic [DATA_W-1:0] r_s2Data;
  logic              r_s2Err;
  logic [15:0]       r_xferCnt;

  logic              w_s1Ready;
  logic              w_s2Ready;
  logic              w_inFire;
  logic              w_outFire;

  logic [DATA_W-1:0] w_bitRev;
  logic [DATA_W-1:0] w_laneRev;
  logic [DATA_W-1:0] w_inLaneRev;
  logic [DATA_W-1:0] w_swapHalf;
  logic [DATA_W-1:0] w_permData;
  logic              w_permErr;

  // Ready chain: a stage can take a new word when it is empty or when its
  // current word leaves in the same cycle. This keeps full throughput with
  // no bubble, at the cost of a combinational path from out_ready to in_ready.
  assign w_s2Ready = !r_s2Valid || out_ready;
  assign w_s1Ready = !r_s1Valid || w_s2Ready;
  assign w_inFire  = in_valid && w_s1Ready;
  assign w_outFire = r_s2Valid && out_ready;

  assign in_ready  = w_s1Ready;
  assign out_valid = r_s2Valid;
  assign out_data  = r_s2Data;
  assign out_err   = r_s2Err;
  assign xfer_cnt  = r_xferCnt;

`ifdef VECTOR_REORDER_ROTATE_EN
  logic [ROT_W-1:0]  r_s1Rot;
  logic [DATA_W-1:0] w_rotData;

  // Rotate left by a compile-time constant amount; each barrel stage uses one.
  function automatic logic [DATA_W-1:0] rotlConst(input logic [DATA_W-1:0] value,
                                                  input int              amount);
    logic [DATA_W-1:0] result;
    result = '0;
    for (int i = 0; i < DATA_W; i++) begin
      result[i] = value[(i + DATA_W - amount) % DATA_W];
    end
    return result;
  endfunction

  // Barrel rotator: stage s rotates by 2^s mod DATA_W. Rotations compose
  // additively modulo DATA_W, so this yields rot mod DATA_W even when
  // DATA_W is not a power of two.
  always_comb begin
    w_rotData = r_s1Data;
    for (int s = 0; s < ROT_W; s++) begin
      if (r_s1Rot[s]) begin
        w_rotData = rotlConst(w_rotData, (1 << s) % DATA_W);
      end
    end
  end

  // Rotate amount travels with its word through stage 1.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1Rot <= '0;
    end else if (w_inFire) begin
      r_s1Rot <= in_rot;
    end
  end
`else
  // Without the rotator the rotate amount has no consumer.
  logic w_unusedRot;
  assign w_unusedRot = ^in_rot;
`endif

  // Full bit reversal across the whole word.
  always_comb begin
    w_bitRev = '0;
    for (int i = 0; i < DATA_W; i++) begin
      w_bitRev[i] = r_s1Data[DATA_W-1-i];
    end
  end

  // Lane reversal keeps bit order inside each lane; in-lane reversal keeps
  // lane order but flips bits inside every lane.
  always_comb begin
    w_laneRev   = '0;
    w_inLaneRev = '0;
    for (int k = 0; k < LANES; k++) begin
      for (int j = 0; j < LANE_W; j++) begin
        w_laneRev[k*LANE_W + j]   = r_s1Data[(LANES-1-k)*LANE_W + j];
        w_inLaneRev[k*LANE_W + j] = r_s1Data[k*LANE_W + LANE_W-1-j];
      end
    end
  end

  // LANES is even, so the word always splits into two equal halves.
  assign w_swapHalf = {r_s1Data[HALF_W-1:0], r_s1Data[DATA_W-1:HALF_W]};

  // Mode select. Illegal words are still delivered, but with zero data and
  // the error flag set, so the consumer sees every accepted transaction.
  always_comb begin
    w_permData = '0;
    w_permErr  = 1'b0;
    case (r_s1Mode)
      MODE_PASS:     w_permData = r_s1Data;
      MODE_BITREV:   w_permData = w_bitRev;
      MODE_LANEREV:  w_permData = w_laneRev;
      MODE_INLANE:   w_permData = w_inLaneRev;
      MODE_SWAPHALF: w_permData = w_swapHalf;
`ifdef VECTOR_REORDER_ROTATE_EN
      MODE_ROTL:     w_permData = w_rotData;
`else
      MODE_ROTL:     w_permErr  = 1'b1;
`endif
      default:       w_permErr  = 1'b1;
    endcase
  end

  // Stage 1 register. Whenever stage 1 can advance it either takes the new
  // input word or empties; the payload only changes on a real handshake,
  // so inputs wiggling while stalled are never captured.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1Valid <= 1'b0;
      r_s1Data  <= '0;
      r_s1Mode  <= MODE_PASS;
    end else if (w_s1Ready) begin
      r_s1Valid <= in_valid;
      if (in_valid) begin
        r_s1Data <= in_data;
        r_s1Mode <= mode_e'(in_mode);
      end
    end
  end

  // Stage 2 register. Holds its word steady while the consumer stalls.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s2Valid <= 1'b0;
      r_s2Data  <= '0;
      r_s2Err   <= 1'b0;
    end else if (w_s2Ready) begin
      r_s2Valid <= r_s1Valid;
      if (r_s1Valid) begin
        r_s2Data <= w_permData;
        r_s2Err  <= w_permErr;
      end
    end
  end

  // Completed output handshakes, including illegal-mode words; wraps freely.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_xferCnt <= '0;
    end else if (w_outFire) begin
      r_xferCnt <= r_xferCnt + 16'd1;
    end
  end

endmodule

// File: tb/tb_vector_reorder_pipe.sv
// tb_vector_reorder_pipe
//
// Self-checking bench for vector_reorder_pipe with LANES=4, LANE_W=4.
// A table of {input, expected output} records is streamed at full rate,
// followed by hand-written sequences for backpressure, mid-stream reset
// and xfer_cnt wrap. Mode 5 expectations follow VECTOR_REORDER_ROTATE_EN.

module tb_vector_reorder_pipe;

   localparam int LANES  = 4;
   localparam int LANE_W = 4;
   localparam int DATA_W = 16;
   localparam int ROT_W  = 4;

   logic              clk = 1'b0;
   logic              rst_n = 1'b0;
   logic              in_valid = 1'b0;
   logic              in_ready;
   logic [DATA_W-1:0] in_data = '0;
   logic [2:0]        in_mode = '0;
   logic [ROT_W-1:0]  in_rot = '0;
   logic              out_valid;
   logic              out_ready = 1'b0;
   logic [DATA_W-1:0] out_data;
   logic              out_err;
   logic [15:0]       xfer_cnt;

   int errCount   = 0;
   int checkCount = 0;
   int expCnt     = 0;

   typedef struct {
      logic [15:0] data;
      logic [2:0]  mode;
      logic [3:0]  rot;
      logic [15:0] expData;
      logic        expErr;
   } vec_t;

   vec_t vecs[$];

   vector_reorder_pipe #(
      .LANES  (LANES),
      .LANE_W (LANE_W)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
      .in_mode   (in_mode),
      .in_rot    (in_rot),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .out_err   (out_err),
      .xfer_cnt  (xfer_cnt)
   );

   // Free-running 10-unit clock.
   always #5 clk = ~clk;

   // Guard against a hung run: report and stop.
   initial begin
      #5000000;
      $display("[TB] FAIL watchdog: time limit reached, errors=%0d checks=%0d", errCount, checkCount);
      $fatal(1, "[TB] watchdog expired");
   end

   // Drive the producer side of the pipe.
   task automatic applyStimulus(input logic v, input logic [15:0] d,
                                input logic [2:0] m, input logic [3:0] r);
      in_valid = v;
      in_data  = d;
      in_mode  = m;
      in_rot   = r;
   endtask

   // Compare one observed value against its expected value.
   task automatic checkOutput(input string name, input logic [31:0] actual,
                              input logic [31:0] expected);
      checkCount++;
      if (actual !== expected) begin
         errCount++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
      end
   endtask

   // Advance to just after the next rising edge.
   task automatic nextCycle();
      @(posedge clk);
      #1;
   endtask

   function automatic void addVec(input logic [15:0] d, input logic [2:0] m,
                                  input logic [3:0] r, input logic [15:0] ed,
                                  input logic ee);
      vec_t v;
      v.data    = d;
      v.mode    = m;
      v.rot     = r;
      v.expData = ed;
      v.expErr  = ee;
      vecs.push_back(v);
   endfunction

   // Main test sequence
   initial begin
      int remaining;
      logic stallSeen;

      // Hand-computed vectors
      addVec(16'h1234, 3'd0, 4'd0, 16'h1234, 1'b0);
      addVec(16'h1234, 3'd1, 4'd0, 16'h2C48, 1'b0);
      addVec(16'h1234, 3'd2, 4'd0, 16'h4321, 1'b0);
      addVec(16'h1234, 3'd3, 4'd0, 16'h84C2, 1'b0);
      addVec(16'h1234, 3'd4, 4'd0, 16'h3412, 1'b0);
`ifdef VECTOR_REORDER_ROTATE_EN
      addVec(16'h1234, 3'd5, 4'd4,  16'h2341, 1'b0);
      addVec(16'h1234, 3'd5, 4'd15, 16'h091A, 1'b0);
      addVec(16'h8000, 3'd5, 4'd1,  16'h0001, 1'b0);
      addVec(16'h1234, 3'd5, 4'd0,  16'h1234, 1'b0);
`else
      addVec(16'h1234, 3'd5, 4'd4,  16'h0000, 1'b1);
      addVec(16'h1234, 3'd5, 4'd15, 16'h0000, 1'b1);
      addVec(16'h8000, 3'd5, 4'd1,  16'h0000, 1'b1);
`endif
      addVec(16'hFFFF, 3'd6, 4'd0, 16'h0000, 1'b1);
      addVec(16'hABCD, 3'd7, 4'd3, 16'h0000, 1'b1);
      addVec(16'hA5C3, 3'd1, 4'd0, 16'hC3A5, 1'b0);
      addVec(16'h8001, 3'd2, 4'd0, 16'h1008, 1'b0);
      addVec(16'h1111, 3'd3, 4'd0, 16'h8888, 1'b0);
      addVec(16'h00FF, 3'd4, 4'd0, 16'hFF00, 1'b0);
      addVec(16'hBEEF, 3'd0, 4'd9, 16'hBEEF, 1'b0);

      // Reset values while rst_n is held low
      applyStimulus(1'b0, '0, '0, '0);
      out_ready = 1'b1;
      nextCycle();
      nextCycle();
      checkOutput("reset out_valid", out_valid, 0);
      checkOutput("reset in_ready", in_ready, 1);
      checkOutput("reset out_data", out_data, 0);
      checkOutput("reset out_err", out_err, 0);
      checkOutput("reset xfer_cnt", xfer_cnt, 0);
      #2 rst_n = 1'b1;
      nextCycle();

      // Table streaming at full rate: word n is presented in cycle n and
      // must be on the output in cycle n+2.
      for (int n = 0; n < vecs.size() + 2; n++) begin
         if (n >= 2) begin
            checkOutput($sformatf("vec%0d out_valid", n-2), out_valid, 1);
            checkOutput($sformatf("vec%0d out_data", n-2), out_data, vecs[n-2].expData);
            checkOutput($sformatf("vec%0d out_err", n-2), out_err, vecs[n-2].expErr);
            checkOutput($sformatf("vec%0d xfer_cnt", n-2), xfer_cnt, expCnt);
            expCnt++;
         end else begin
            checkOutput($sformatf("fill%0d out_valid", n), out_valid, 0);
         end
         if (n < vecs.size()) begin
            applyStimulus(1'b1, vecs[n].data, vecs[n].mode, vecs[n].rot);
            checkOutput($sformatf("vec%0d in_ready", n), in_ready, 1);
         end else begin
            applyStimulus(1'b0, '0, '0, '0);
         end
         nextCycle();
      end
      checkOutput("table drained out_valid", out_valid, 0);
      checkOutput("table xfer_cnt", xfer_cnt, expCnt);

      // Backpressure: two words fill the pipe, the third waits; its mode
      // changes while stalled and only the value at handshake counts.
      out_ready = 1'b0;
      applyStimulus(1'b1, 16'hA000, 3'd0, 4'd0);
      #1 checkOutput("bp accept A", in_ready, 1);
      nextCycle();
      applyStimulus(1'b1, 16'hB000, 3'd0, 4'd0);
      #1 checkOutput("bp accept B", in_ready, 1);
      nextCycle();
      applyStimulus(1'b1, 16'hC000, 3'd6, 4'd0);
      #1 checkOutput("bp full in_ready", in_ready, 0);
      for (int c = 0; c < 3; c++) begin
         nextCycle();
         checkOutput($sformatf("bp hold%0d in_ready", c), in_ready, 0);
         checkOutput($sformatf("bp hold%0d out_valid", c), out_valid, 1);
         checkOutput($sformatf("bp hold%0d out_data", c), out_data, 16'hA000);
         checkOutput($sformatf("bp hold%0d xfer_cnt", c), xfer_cnt, expCnt);
      end
      applyStimulus(1'b1, 16'hC000, 3'd0, 4'd0);
      out_ready = 1'b1;
      #1 checkOutput("bp release in_ready", in_ready, 1);
      nextCycle();
      expCnt++;
      applyStimulus(1'b0, '0, '0, '0);
      checkOutput("bp out B valid", out_valid, 1);
      checkOutput("bp out B data", out_data, 16'hB000);
      nextCycle();
      expCnt++;
      checkOutput("bp out C valid", out_valid, 1);
      checkOutput("bp out C data", out_data, 16'hC000);
      checkOutput("bp out C err", out_err, 0);
      nextCycle();
      expCnt++;
      checkOutput("bp drained out_valid", out_valid, 0);
      checkOutput("bp xfer_cnt", xfer_cnt, expCnt);

      // Reset while both stages hold words
      out_ready = 1'b0;
      applyStimulus(1'b1, 16'h1111, 3'd0, 4'd0);
      nextCycle();
      applyStimulus(1'b1, 16'h2222, 3'd0, 4'd0);
      nextCycle();
      applyStimulus(1'b0, '0, '0, '0);
      checkOutput("rst pre out_valid", out_valid, 1);
      checkOutput("rst pre in_ready", in_ready, 0);
      #1 rst_n = 1'b0;
      #1;
      expCnt = 0;
      checkOutput("rst mid out_valid", out_valid, 0);
      checkOutput("rst mid xfer_cnt", xfer_cnt, 0);
      checkOutput("rst mid in_ready", in_ready, 1);
      checkOutput("rst mid out_data", out_data, 0);
      checkOutput("rst mid out_err", out_err, 0);
      nextCycle();
      #2 rst_n = 1'b1;
      out_ready = 1'b1;
      applyStimulus(1'b1, 16'h5A5A, 3'd2, 4'd0);
      nextCycle();
      applyStimulus(1'b0, '0, '0, '0);
      checkOutput("rst post +1 out_valid", out_valid, 0);
      nextCycle();
      checkOutput("rst post +2 out_valid", out_valid, 1);
      checkOutput("rst post +2 out_data", out_data, 16'hA5A5);
      expCnt++;
      nextCycle();
      checkOutput("rst post drained", out_valid, 0);
      checkOutput("rst post xfer_cnt", xfer_cnt, expCnt);

      // Counter wrap: stream until the count reaches 0xFFFF, then one more.
      remaining = 65535 - expCnt;
      stallSeen = 1'b0;
      for (int i = 0; i < remaining; i++) begin
         applyStimulus(1'b1, 16'(i), 3'd0, 4'd0);
         if (in_ready !== 1'b1) stallSeen = 1'b1;
         nextCycle();
      end
      applyStimulus(1'b0, '0, '0, '0);
      nextCycle();
      nextCycle();
      checkOutput("wrap stream stall", stallSeen, 0);
      checkOutput("wrap preload xfer_cnt", xfer_cnt, 16'hFFFF);
      applyStimulus(1'b1, 16'h7777, 3'd6, 4'd0);
      nextCycle();
      applyStimulus(1'b0, '0, '0, '0);
      nextCycle();
      checkOutput("wrap last out_err", out_err, 1);
      checkOutput("wrap last out_data", out_data, 0);
      nextCycle();
      checkOutput("wrap xfer_cnt", xfer_cnt, 16'h0000);

      $display("Result: errors=%0d of %0d checks", errCount, checkCount);
      $finish;
   end

endmodule

// File: doc/vector_reorder_pipe.md
# vector_reorder_pipe

Parametrised, pipelined bit/lane reordering unit with a valid/ready handshake on both sides. Each transaction carries a DATA_W-bit word and a mode code. The block applies the selected permutation (full bit reversal, lane reversal, in-lane bit reversal, half swap, optional rotate) and delivers the result two cycles later. It sits between a producer and a consumer that disagree on vector range direction or lane ordering, and sustains one word per clock under full flow.

## Interface
Parameters:
- LANES, default 4: number of lanes; must be ≥2 and even.
- LANE_W, default 4: bits per lane; must be ≥1.
- DATA_W (localparam) = LANES*LANE_W. ROT_W (localparam) = $clog2(DATA_W).

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  input word valid.
- in_ready  output  1  block accepts the input word this cycle.
- in_data  input  DATA_W  input word, bit DATA_W-1 = MSB.
- in_mode  input  3  permutation select, sampled with in_data.
- in_rot  input  ROT_W  rotate amount for mode 5, sampled with in_data.
- out_valid  output  1  output word valid.
- out_ready  input  1  consumer accepts the output word.
- out_data  output  DATA_W  permuted word.
- out_err  output  1  qualifies out_data; 1 = illegal mode, out_data forced to 0.
- xfer_cnt  output  16  count of completed output handshakes; wraps at 0xFFFF→0.

## Operation
- Input handshake: in_valid && in_ready. Output handshake: out_valid && out_ready.
- Stage 1 (S1) registers in_data, in_mode and in_rot. Stage 2 (S2) registers the permuted result and the error flag.
- Modes, with bit index i in 0..DATA_W-1, lane k in 0..LANES-1, and in-lane bit j in 0..LANE_W-1:
  - 0 PASS: out = in.
  - 1 BITREV: out[i] = in[DATA_W-1-i].
  - 2 LANEREV: out lane k = in lane LANES-1-k; bit order within each lane is kept.
  - 3 INLANE: out[k*LANE_W+j] = in[k*LANE_W+LANE_W-1-j].
  - 4 SWAPHALF: out = {in[DATA_W/2-1:0], in[DATA_W-1:DATA_W/2]}.
  - 5 ROTL: rotate left by (in_rot mod DATA_W). Available only with the macro; see Configuration.
  - 6, 7: illegal. out_data = 0 and out_err = 1; the word is still delivered and still counted.
- Mode and rot are bound per transaction. Changing in_mode while in_valid is held without a handshake has no effect until the handshake occurs.
- Data and mode held in a stalled stage stay stable until that stage hands off.

## Timing
- Latency: 2 cycles from the input handshake edge to out_valid, with no stall.
- Throughput: 1 word/cycle when out_ready = 1.
- Ready chain:
  - s2_ready = !s2_valid || out_ready.
  - s1_ready = !s1_valid || s2_ready.
  - in_ready = s1_ready (combinational from out_ready; no registered skid).
- Full pipeline with out_ready = 0: holds 2 words; in_ready = 0.
- Simultaneous out handshake and in handshake on a full pipe: both complete in the same cycle, with no bubble.
- xfer_cnt increments on the output handshake cycle.
- Reset values, applied immediately when rst_n asserts, including mid-transfer: s1_valid = s2_valid = 0, out_valid = 0, out_data = 0, out_err = 0, xfer_cnt = 0, and in_ready = 1. Words in flight are discarded.
- First possible input handshake is on the first rising edge after rst_n deasserts.

## Configuration
- VECTOR_REORDER_ROTATE_EN defined: mode 5 ROTL is legal, and the S2 rotator (barrel, log2 stages) is built.
- Not defined: no rotator logic exists. Mode 5 is treated as illegal (out_data = 0, out_err = 1), and in_rot is ignored.

## Test plan
Use LANES=4, LANE_W=4 throughout.
- Mode sweep, out_ready = 1: in_data 0x1234 with modes 0..4 → out_data 0x1234, 0x2C48, 0x4321, 0x84C2, 0x3412 on consecutive cycles, each 2 cycles after its input, out_err = 0.
- Rotate with macro defined: 0x1234, mode 5, rot 4 → 0x2341. Rot 15 → 0x091A. Same stimulus without the macro → out_data 0x0000, out_err = 1.
- Illegal mode: 0xFFFF with mode 6 → out_data 0x0000, out_err = 1, xfer_cnt increments.
- Backpressure: hold out_ready = 0 and stream 0xA000, 0xB000, 0xC000 in PASS mode → in_ready drops after 2 accepts. Release out_ready → outputs 0xA000, 0xB000, 0xC000 in order, with none lost or duplicated.
- Reset mid-stream: assert rst_n = 0 while both stages are valid → out_valid = 0 and xfer_cnt = 0 immediately. After release, the first new word emerges 2 cycles after its handshake.
- Counter wrap: preload xfer_cnt to 0xFFFF by issuing 65535 transfers, then one more transfer → xfer_cnt = 0x0000.
